// File: rtl/bridge_pkg.sv
// Shared types and default address map for the CPU-to-peripheral bus bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } bridge_state_t;

    // Default MIPS SoC map: data memory, two timers, spare/interrupt window.
    localparam logic [31:0] DM_BASE  = 32'h0000_0000;
    localparam logic [31:0] DM_MASK  = 32'hFFFF_C000;
    localparam logic [31:0] TC0_BASE = 32'h0000_7F00;
    localparam logic [31:0] TC0_MASK = 32'hFFFF_FFF0;
    localparam logic [31:0] TC1_BASE = 32'h0000_7F10;
    localparam logic [31:0] TC1_MASK = 32'hFFFF_FFF0;
    localparam logic [31:0] INT_BASE = 32'h0000_7F20;
    localparam logic [31:0] INT_MASK = 32'hFFFF_FFFC;

    localparam int          DEF_NUM_SLV  = 4;
    localparam logic [127:0] DEF_SLV_BASE = {INT_BASE, TC1_BASE, TC0_BASE, DM_BASE};
    localparam logic [127:0] DEF_SLV_MASK = {INT_MASK, TC1_MASK, TC0_MASK, DM_MASK};

    localparam logic [3:0] BYTEEN_READ = 4'b0000;
    localparam logic [3:0] BYTEEN_WORD = 4'b1111;

    function automatic logic is_partial_write(input logic [3:0] byteen);
        return (byteen != BYTEEN_READ) && (byteen != BYTEEN_WORD);
    endfunction

endpackage

// File: rtl/sys_bus_bridge_if.sv
// CPU-side and peripheral-side signals of the bus bridge. The master modport is the
// bridge itself (it masters the peripheral bus); slave is the CPU/peripheral side.
// BRIDGE_ERRLOG_EN adds the error-log outputs err_addr and err_cnt.
interface sys_bus_bridge_if #(
    parameter int NUM_SLV = 4
);
    logic                   cpu_req;
    logic [31:0]            cpu_addr;
    logic [3:0]             cpu_byteen;
    logic [31:0]            cpu_wdata;
    logic                   cpu_ready;
    logic                   cpu_rvalid;
    logic [31:0]            cpu_rdata;
    logic                   cpu_err;
    logic [NUM_SLV-1:0]     slv_sel;
    logic [31:0]            slv_addr;
    logic [3:0]             slv_byteen;
    logic [31:0]            slv_wdata;
    logic [NUM_SLV*32-1:0]  slv_rdata;
    logic [NUM_SLV-1:0]     slv_ack;
`ifdef BRIDGE_ERRLOG_EN
    logic [31:0]            err_addr;
    logic [7:0]             err_cnt;
`endif

    modport master (
        input  cpu_req, cpu_addr, cpu_byteen, cpu_wdata, slv_rdata, slv_ack,
        output cpu_ready, cpu_rvalid, cpu_rdata, cpu_err,
        output slv_sel, slv_addr, slv_byteen, slv_wdata
`ifdef BRIDGE_ERRLOG_EN
        , output err_addr, err_cnt
`endif
    );

    modport slave (
        output cpu_req, cpu_addr, cpu_byteen, cpu_wdata, slv_rdata, slv_ack,
        input  cpu_ready, cpu_rvalid, cpu_rdata, cpu_err,
        input  slv_sel, slv_addr, slv_byteen, slv_wdata
`ifdef BRIDGE_ERRLOG_EN
        , input err_addr, err_cnt
`endif
    );

endinterface

// File: rtl/bridge_addr_decode.sv
// Combinational window decoder: lowest-index matching window wins; flags partial
// writes aimed at word-only slaves.
module bridge_addr_decode
    import bridge_pkg::*;
#(
    parameter int                    NUM_SLV       = DEF_NUM_SLV,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE      = DEF_SLV_BASE,
    parameter logic [NUM_SLV*32-1:0] SLV_MASK      = DEF_SLV_MASK,
    parameter logic [NUM_SLV-1:0]    SLV_WORD_ONLY = 4'b0110
) (
    input  logic [31:0]        addr,
    input  logic [3:0]         byteen,
    output logic [NUM_SLV-1:0] hit,
    output logic               any_hit,
    output logic               word_only_violation
);

    logic [NUM_SLV-1:0] raw_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_win
            assign raw_hit[gi] = (addr & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32];
        end
    endgenerate

    // Isolate the lowest set bit so overlapping windows resolve by index.
    assign hit                 = raw_hit & (~raw_hit + NUM_SLV'(1));
    assign any_hit             = |raw_hit;
    assign word_only_violation = (|(hit & SLV_WORD_ONLY)) && is_partial_write(byteen);

endmodule

// File: rtl/sys_bus_bridge.sv
// Handshaked CPU-to-peripheral bridge: one outstanding request, window decode,
// slave ack with timeout, bus-error completion. Optional BRIDGE_ERRLOG_EN error log.
module sys_bus_bridge
    import bridge_pkg::*;
#(
    parameter int                    NUM_SLV       = DEF_NUM_SLV,
    parameter logic [NUM_SLV*32-1:0] SLV_BASE      = DEF_SLV_BASE,
    parameter logic [NUM_SLV*32-1:0] SLV_MASK      = DEF_SLV_MASK,
    parameter logic [NUM_SLV-1:0]    SLV_WORD_ONLY = 4'b0110,
    parameter int                    TIMEOUT       = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    sys_bus_bridge_if.master bus
);

    localparam int             CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    bridge_state_t      state_reg, state_next;
    logic [NUM_SLV-1:0] sel_reg, sel_next;
    logic [31:0]        addr_reg, addr_next;
    logic [3:0]         byteen_reg, byteen_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic [31:0]        rdata_reg, rdata_next;
    logic               rvalid_reg, rvalid_next;
    logic               err_reg, err_next;
    logic [CW-1:0]      cnt_reg, cnt_next;

    logic [NUM_SLV-1:0] dec_hit;
    logic               dec_any_hit;
    logic               dec_violation;
    logic               sel_ack;
    logic [31:0]        sel_rdata;

    bridge_addr_decode #(
        .NUM_SLV       (NUM_SLV),
        .SLV_BASE      (SLV_BASE),
        .SLV_MASK      (SLV_MASK),
        .SLV_WORD_ONLY (SLV_WORD_ONLY)
    ) u_decode (
        .addr                (bus.cpu_addr),
        .byteen              (bus.cpu_byteen),
        .hit                 (dec_hit),
        .any_hit             (dec_any_hit),
        .word_only_violation (dec_violation)
    );

    // Only the selected slave's ack and data are honoured; others are masked off.
    assign sel_ack = |(sel_reg & bus.slv_ack);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_reg[i]) begin
                sel_rdata = bus.slv_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        sel_next    = sel_reg;
        addr_next   = addr_reg;
        byteen_next = byteen_reg;
        wdata_next  = wdata_reg;
        rdata_next  = rdata_reg;
        err_next    = err_reg;
        rvalid_next = 1'b0;
        cnt_next    = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cpu_req) begin
                    addr_next   = bus.cpu_addr;
                    byteen_next = bus.cpu_byteen;
                    wdata_next  = bus.cpu_wdata;
                    if (!dec_any_hit || dec_violation) begin
                        state_next  = RESP;
                        rvalid_next = 1'b1;
                        err_next    = 1'b1;
                        rdata_next  = '0;
                    end else begin
                        state_next = ACCESS;
                        sel_next   = dec_hit;
                        cnt_next   = '0;
                    end
                end
            end
            ACCESS: begin
                // An ack in the final timeout cycle still completes without error.
                if (sel_ack) begin
                    state_next  = RESP;
                    sel_next    = '0;
                    rvalid_next = 1'b1;
                    err_next    = 1'b0;
                    rdata_next  = (byteen_reg == BYTEEN_READ) ? sel_rdata : 32'h0;
                end else if (cnt_reg == CNT_LAST) begin
                    state_next  = RESP;
                    sel_next    = '0;
                    rvalid_next = 1'b1;
                    err_next    = 1'b1;
                    rdata_next  = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                sel_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= IDLE;
            sel_reg    <= '0;
            addr_reg   <= '0;
            byteen_reg <= '0;
            wdata_reg  <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            sel_reg    <= sel_next;
            addr_reg   <= addr_next;
            byteen_reg <= byteen_next;
            wdata_reg  <= wdata_next;
            rdata_reg  <= rdata_next;
            rvalid_reg <= rvalid_next;
            err_reg    <= err_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign bus.cpu_ready  = (state_reg == IDLE);
    assign bus.cpu_rvalid = rvalid_reg;
    assign bus.cpu_rdata  = rdata_reg;
    assign bus.cpu_err    = err_reg;
    assign bus.slv_sel    = sel_reg;
    assign bus.slv_addr   = addr_reg;
    assign bus.slv_byteen = byteen_reg;
    assign bus.slv_wdata  = wdata_reg;

`ifdef BRIDGE_ERRLOG_EN
    logic [31:0] err_addr_reg;
    logic [7:0]  err_cnt_reg;

    // Logged on the same edge that raises the error response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_addr_reg <= '0;
            err_cnt_reg  <= '0;
        end else if (rvalid_next && err_next) begin
            err_addr_reg <= addr_next;
            if (err_cnt_reg != 8'hFF) begin
                err_cnt_reg <= err_cnt_reg + 8'd1;
            end
        end
    end

    assign bus.err_addr = err_addr_reg;
    assign bus.err_cnt  = err_cnt_reg;
`endif

endmodule

// File: tb/tb_sys_bus_bridge.sv
// Self-checking bench for sys_bus_bridge: directed cases, random traffic against a
// transaction-level model, async reset mid-access, error-log saturation.
`timescale 1ns/1ps
module tb_sys_bus_bridge;
    import bridge_pkg::*;

    localparam int NS = 4;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sys_bus_bridge_if #(.NUM_SLV(NS)) bus();

    sys_bus_bridge #(.NUM_SLV(NS), .TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] m_base [NS] = '{32'h0000_0000, 32'h0000_7F00, 32'h0000_7F10, 32'h0000_7F20};
    logic [31:0] m_mask [NS] = '{32'hFFFF_C000, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFFC};
    bit          m_word_only [NS] = '{1'b0, 1'b1, 1'b1, 1'b0};

    int          n_checks = 0;
    int          n_errors = 0;
    int          m_err_cnt = 0;
    logic [31:0] m_err_addr = '0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int ref_target(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    // ack_at: the sel cycle (1-based) in which the target acks; 0 or >TO means never.
    task automatic run_txn(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                           input int ack_at, input string name);
        int          tgt, exp_sel_cycles, exp_lat, lat, sel_cycles, w;
        bit          exp_err, done, sel_bad, lat_bad;
        logic [31:0] exp_rdata;
        logic [31:0] rd [NS];
        logic [NS-1:0] exp_onehot, stray;

        tgt        = ref_target(a);
        exp_onehot = '0;
        exp_rdata  = '0;
        if (tgt < 0 || (m_word_only[tgt] && be != 4'b0000 && be != 4'b1111)) begin
            exp_err        = 1'b1;
            exp_sel_cycles = 0;
            exp_lat        = 1;
        end else begin
            exp_onehot[tgt] = 1'b1;
            if (ack_at >= 1 && ack_at <= TO) begin
                exp_err        = 1'b0;
                exp_sel_cycles = ack_at;
            end else begin
                exp_err        = 1'b1;
                exp_sel_cycles = TO;
            end
            exp_lat = exp_sel_cycles + 1;
        end
        for (int i = 0; i < NS; i++) begin
            rd[i] = $urandom;
            bus.slv_rdata[32*i +: 32] = rd[i];
        end
        if (!exp_err && be == 4'b0000) exp_rdata = rd[tgt];

        w = 0;
        while (bus.cpu_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check_val({name, ":ready"}, {31'b0, bus.cpu_ready}, 32'd1);

        bus.cpu_req    = 1'b1;
        bus.cpu_addr   = a;
        bus.cpu_byteen = be;
        bus.cpu_wdata  = wd;

        lat = 0; sel_cycles = 0; done = 1'b0; sel_bad = 1'b0; lat_bad = 1'b0;
        while (!done && lat < TO + 10) begin
            @(negedge clk);
            lat++;
            if (bus.slv_sel != '0) begin
                sel_cycles++;
                if (bus.slv_sel !== exp_onehot || bus.slv_addr !== a ||
                    bus.slv_byteen !== be || bus.slv_wdata !== wd) sel_bad = 1'b1;
            end
            if (bus.cpu_rvalid === 1'b1) begin
                done = 1'b1;
                bus.cpu_req = 1'b0;
                bus.slv_ack = NS'($urandom);
            end else begin
                if (bus.cpu_ready !== 1'b0) lat_bad = 1'b1;
                // Junk requests while busy must be ignored.
                bus.cpu_req    = 1'($urandom_range(0, 1));
                bus.cpu_addr   = $urandom;
                bus.cpu_byteen = 4'($urandom);
                bus.cpu_wdata  = $urandom;
                stray = NS'($urandom) & ~exp_onehot;
                if (bus.slv_sel != '0 && sel_cycles == ack_at) stray = stray | exp_onehot;
                bus.slv_ack = stray;
            end
        end
        bus.cpu_req = 1'b0;
        if (!done) check_val({name, ":rvalid_seen"}, 32'd0, 32'd1);
        check_val({name, ":latency"}, lat, exp_lat);
        check_val({name, ":err"}, {31'b0, bus.cpu_err}, {31'b0, exp_err});
        check_val({name, ":rdata"}, bus.cpu_rdata, exp_rdata);
        check_val({name, ":sel_cycles"}, sel_cycles, exp_sel_cycles);
        check_val({name, ":sel_bus_ok"}, {31'b0, sel_bad}, 32'd0);
        check_val({name, ":busy_ready"}, {31'b0, lat_bad}, 32'd0);
`ifdef BRIDGE_ERRLOG_EN
        if (exp_err) begin
            m_err_addr = a;
            if (m_err_cnt < 255) m_err_cnt++;
        end
        check_val({name, ":err_addr"}, bus.err_addr, m_err_addr);
        check_val({name, ":err_cnt"}, {24'b0, bus.err_cnt}, 32'(m_err_cnt));
`endif
        @(negedge clk);
        check_val({name, ":rvalid_drop"}, {31'b0, bus.cpu_rvalid}, 32'd0);
        check_val({name, ":ready_back"}, {31'b0, bus.cpu_ready}, 32'd1);
        check_val({name, ":rdata_hold"}, bus.cpu_rdata, exp_rdata);
        check_val({name, ":err_hold"}, {31'b0, bus.cpu_err}, {31'b0, exp_err});
        bus.slv_ack = '0;
        $display("txn %-10s addr=%08h be=%04b ack_at=%0d -> lat=%0d err=%0b rdata=%08h",
                 name, a, be, ack_at, lat, bus.cpu_err, bus.cpu_rdata);
    endtask

    initial begin
        logic [31:0] a;
        logic [3:0]  be;

        reset_n        = 1'b0;
        bus.cpu_req    = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_byteen = '0;
        bus.cpu_wdata  = '0;
        bus.slv_rdata  = '0;
        bus.slv_ack    = '0;
        repeat (3) @(negedge clk);
        check_val("rst:ready", {31'b0, bus.cpu_ready}, 32'd1);
        check_val("rst:rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
        check_val("rst:err", {31'b0, bus.cpu_err}, 32'd0);
        check_val("rst:rdata", bus.cpu_rdata, 32'd0);
        check_val("rst:sel", {28'b0, bus.slv_sel}, 32'd0);
        check_val("rst:slv_addr", bus.slv_addr, 32'd0);
        check_val("rst:slv_byteen", {28'b0, bus.slv_byteen}, 32'd0);
        check_val("rst:slv_wdata", bus.slv_wdata, 32'd0);
        reset_n = 1'b1;

        run_txn(32'h0000_1000, 4'b0000, 32'h0,         1,  "dm_read");
        run_txn(32'h0000_7F04, 4'b1111, 32'h1234_5678, 3,  "tc0_write");
        run_txn(32'h0000_7F14, 4'b0011, 32'hA5A5_A5A5, 1,  "tc1_part");
        run_txn(32'h0000_5000, 4'b0000, 32'h0,         1,  "unmapped");
        run_txn(32'h0000_7F20, 4'b0000, 32'h0,         0,  "timeout");
        run_txn(32'h0000_7F20, 4'b0000, 32'h0,         TO, "ack_last");
        run_txn(32'h0000_3FFC, 4'b0101, 32'hCAFE_F00D, 2,  "dm_part");

        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'($urandom_range(0, 32'h3FFF));
                1:       a = 32'h7F00 + 32'($urandom_range(0, 15));
                2:       a = 32'h7F10 + 32'($urandom_range(0, 15));
                3:       a = 32'h7F20 + 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0:       be = 4'b0000;
                1:       be = 4'b1111;
                default: be = 4'($urandom);
            endcase
            run_txn(a, be, $urandom, int'($urandom_range(0, TO + 2)), "random");
        end

        // Asynchronous reset in the middle of an access.
        bus.slv_ack    = '0;
        bus.cpu_req    = 1'b1;
        bus.cpu_addr   = 32'h0000_7F20;
        bus.cpu_byteen = 4'b0000;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        check_val("arst:sel_pre", {28'b0, bus.slv_sel}, 32'h8);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check_val("arst:sel", {28'b0, bus.slv_sel}, 32'd0);
        check_val("arst:rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
        check_val("arst:ready", {31'b0, bus.cpu_ready}, 32'd1);
        repeat (2) begin
            @(negedge clk);
            check_val("arst:no_rvalid", {31'b0, bus.cpu_rvalid}, 32'd0);
        end
        reset_n    = 1'b1;
        m_err_cnt  = 0;
        m_err_addr = '0;
`ifdef BRIDGE_ERRLOG_EN
        check_val("arst:err_cnt", {24'b0, bus.err_cnt}, 32'd0);
        check_val("arst:err_addr", bus.err_addr, 32'd0);
`endif
        run_txn(32'h0000_0000, 4'b0000, 32'h0, 1, "post_rst");

        // Enough errors to push an 8-bit error counter into saturation.
        for (int n = 0; n < 260; n++) begin
            run_txn(32'h0001_0000 + 32'(n), 4'b0000, 32'h0, 1, "sat");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
